mbe_r8_stream_encoder: RTL

Parametrised, sequential radix-8 Modified Booth recoder for the MBE multiplier datapath.
- Captures one mantissa per transaction through a valid/ready handshake.
- Recodes it into NBLOCK signed digits in the range -4..+4.
- Streams DIGITS_PER_CYCLE digits per beat to the partial-product generator, so a narrower PP array can be reused over several cycles.

---
 rtl/mbe_r8_stream_encoder.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/mbe_r8_stream_encoder.sv
// Streaming radix-8 Modified Booth recoder: one operand in, NBEAT beats of signed digits out.
// Build option MBE_R8_SIGNED_EN treats i_mantissa as two's complement (sign-extended pad).
module mbe_r8_stream_encoder #(
  parameter int NBIT_MANTISSA    = 23,
  parameter int DIGITS_PER_CYCLE = 3,
  localparam int W      = NBIT_MANTISSA + 1,
  localparam int NBLOCK = (W + 1 + 2) / 3,
  localparam int NBEAT  = (NBLOCK + DIGITS_PER_CYCLE - 1) / DIGITS_PER_CYCLE,
  localparam int BW     = (NBEAT > 1) ? $clog2(NBEAT) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_valid,
  output logic                          o_ready,
  input  logic [W-1:0]                  i_mantissa,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic [4*DIGITS_PER_CYCLE-1:0] o_digits,
  output logic [BW-1:0]                 o_beat,
  output logic                          o_last,
  output logic                          o_zero
);

  localparam int XW    = 3 * NBLOCK + 1;
  localparam int PADW  = XW - W - 1;
  localparam int NSLOT = NBEAT * DIGITS_PER_CYCLE;
  localparam int DW    = 4 * DIGITS_PER_CYCLE;
  localparam logic [BW-1:0] LAST_BEAT = BW'(NBEAT - 1);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t          state_reg, state_next;
  logic [BW-1:0]   beat_reg, beat_next;
  logic [XW-1:0]   x_reg, x_next;
  logic            zero_reg, zero_next;
  logic [XW-1:0]   x_in;
  logic            last_beat;
  logic [NSLOT*4-1:0] slot_flat;

  // Window -> {neg, magnitude}; 0000 and 1111 both map to +0.
  function automatic logic [3:0] recode(input logic [3:0] w);
    logic [3:0] r;
    r = 4'b0000;
    case (w)
      4'b0001, 4'b0010: r = 4'b0001;
      4'b0011, 4'b0100: r = 4'b0010;
      4'b0101, 4'b0110: r = 4'b0011;
      4'b0111:          r = 4'b0100;
      4'b1000:          r = 4'b1100;
      4'b1001, 4'b1010: r = 4'b1011;
      4'b1011, 4'b1100: r = 4'b1010;
      4'b1101, 4'b1110: r = 4'b1001;
      default:          r = 4'b0000;
    endcase
    return r;
  endfunction

`ifdef MBE_R8_SIGNED_EN
  assign x_in = {{PADW{i_mantissa[W-1]}}, i_mantissa, 1'b0};
`else
  assign x_in = {{PADW{1'b0}}, i_mantissa, 1'b0};
`endif

  assign last_beat = (beat_reg == LAST_BEAT);

  generate
    for (genvar gi = 0; gi < NSLOT; gi++) begin : g_slot
      if (gi < NBLOCK) begin : g_digit
        assign slot_flat[4*gi +: 4] = recode(x_reg[3*gi +: 4]);
      end else begin : g_pad
        assign slot_flat[4*gi +: 4] = 4'b0000;
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
      beat_reg  <= '0;
      x_reg     <= '0;
      zero_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      beat_reg  <= beat_next;
      x_reg     <= x_next;
      zero_reg  <= zero_next;
    end
  end

  // A zero digit needs window 0000 or 1111; overlapping windows plus X[0]=0 force all-zero X.
  always_comb begin
    state_next = state_reg;
    beat_next  = beat_reg;
    x_next     = x_reg;
    zero_next  = zero_reg;
    case (state_reg)
      S_IDLE: begin
        if (i_valid) begin
          state_next = S_RUN;
          beat_next  = '0;
          x_next     = x_in;
          zero_next  = ~|x_in;
        end
      end
      S_RUN: begin
        if (i_ready) begin
          if (last_beat) begin
            beat_next = '0;
            if (i_valid) begin
              x_next    = x_in;
              zero_next = ~|x_in;
            end else begin
              state_next = S_IDLE;
            end
          end else begin
            beat_next = beat_reg + BW'(1);
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_valid  = 1'b0;
    o_ready  = 1'b1;
    o_last   = 1'b0;
    o_zero   = 1'b0;
    o_beat   = beat_reg;
    o_digits = '0;
    if (state_reg == S_RUN) begin
      o_valid  = 1'b1;
      o_ready  = last_beat & i_ready;
      o_last   = last_beat;
      o_zero   = zero_reg;
      o_digits = slot_flat[int'(beat_reg)*DW +: DW];
    end
  end

endmodule
